otbn_rnd_packer: RTL
====================

Name: otbn_rnd_packer

Overview:
- Upstream stage of the OTBN core model. Produces the `edn_rnd_data_valid_i` / `edn_rnd_data_i` inputs that the core model consumes.
- Requests 32-bit words from an EDN-style req/ack endpoint and packs WLEN/32 of them into one WLEN-bit RND word.
- Presents that word with a one-cycle valid pulse.
- Tracks requests that arrive while busy, and supports abort.

Parameters:
- Wlen, 256, width of the packed RND word (equals otbn_pkg::WLEN).
- EdnDataWidth, 32, width of one EDN word.
- NumWords, Wlen/EdnDataWidth (localparam), number of EDN words per RND word; must be >= 2 and a power of two.

Ports:
- clk_i  in  1  clock. One clock domain only.
- rst_i  in  1  reset. Synchronous, active-high.
- rnd_req_i  in  1  single-cycle request for one RND word.
- abort_i  in  1  single-cycle flush; discards partial and pending work.
- edn_req_o  out  1  EDN request; level signal, held while filling.
- edn_ack_i  in  1  EDN word accepted; edn_data_i is valid this cycle.
- edn_data_i  in  EdnDataWidth  EDN word.
- edn_fips_i  in  1  FIPS-compliance flag of the current word.
- rnd_valid_o  out  1  one-cycle pulse; rnd_data_o holds a new word.
- rnd_data_o  out  Wlen  packed RND word.
- rnd_fips_o  out  1  AND of edn_fips_i over all words of the current rnd_data_o.
- busy_o  out  1  high when state != IDLE.
- rnd_words_cnt_o  out  32  completed-word counter (optional feature).

Behaviour:
- Reset values (rst_i sampled at posedge): state IDLE; idx 0; pending 0; rnd_data_o 0; rnd_fips_o 0; rnd_valid_o 0; edn_req_o 0; busy_o 0; rnd_words_cnt_o 0.
- State machine IDLE / FILL / VALID. Transitions are evaluated at posedge.
  - IDLE: rnd_req_i=1 -> FILL with idx=0 and the fips accumulator set to 1.
  - FILL:
    - edn_req_o=1, driven combinationally from the state.
    - Each edn_ack_i=1 writes edn_data_i into staging bits [idx*32 +: 32]; first word lands in the LSBs.
    - Each ack ANDs edn_fips_i into the accumulator and increments idx.
    - An ack with idx==NumWords-1 -> VALID. On that same edge the staging register and accumulator copy to rnd_data_o/rnd_fips_o, so the final word is included.
    - edn_req_o deasserts in the VALID cycle.
  - VALID: rnd_valid_o=1 for exactly this cycle. Next state is FILL (idx=0) if pending=1 or rnd_req_i=1, clearing pending; otherwise IDLE.
- Minimum latency from rnd_req_i to rnd_valid_o is NumWords+1 cycles, reached with ack every cycle (9 cycles at defaults).
- rnd_data_o/rnd_fips_o are stable from VALID until the next VALID. A partial fill never changes them.
- rnd_req_i while in FILL sets pending. At most one request is queued; further requests are absorbed into it.
- edn_ack_i while not in FILL is ignored; data is not stored.
- abort_i has priority over everything else in the same cycle.
  - Next state IDLE; idx, pending and the accumulator are cleared.
  - An ack in the same cycle is ignored.
  - rnd_data_o is kept; no valid pulse is produced.
- abort_i in VALID: that cycle's rnd_valid_o still shows 1 (registered), then the block returns to IDLE.
- rst_i mid-fill: same effect as reset. No valid pulse; edn_req_o is 0 next cycle.
- idx wraps to 0 only through the VALID transition; it never exceeds NumWords-1.

Optional Feature:
- Macro: OTBN_RND_PACKER_CNT_EN.
- Defined: rnd_words_cnt_o increments by 1 on every VALID cycle. It saturates at 32'hFFFF_FFFF and is cleared by rst_i only; abort_i does not clear it.
- Not defined: rnd_words_cnt_o is tied to 0 and no counter flops are built.
- The port exists in both builds.

Decomposition:
- otbn_pkg holds:
  - WLEN;
  - EdnDataWidth = 32;
  - typedef enum logic [1:0] {RndIdle, RndFill, RndValid} rnd_packer_state_e.
- No sub-module: staging register, idx counter and FSM are inlined. The design is small enough that splitting adds no value.

Test Plan:
- Basic pack:
  - Stimulus: rnd_req_i pulse; ack every cycle with data 32'h0000_0001..32'h0000_0008, fips=1.
  - Response: rnd_valid_o rises 9 cycles after the request. rnd_data_o = {32'h8, 32'h7, ..., 32'h1}; rnd_fips_o=1; edn_req_o high for exactly 8 cycles.
- Stalled EDN:
  - Stimulus: acks with 3 idle cycles between each; word 5 carries fips=0.
  - Response: valid comes after 8 acks plus 1 cycle; rnd_fips_o=0; the previous rnd_data_o is unchanged until VALID.
- Back-to-back:
  - Stimulus: a second rnd_req_i during FILL idx=3; acks continuous.
  - Response: two valid pulses 9 cycles apart; edn_req_o drops only in the VALID cycle. A third request in the same FILL adds no extra word.
- Abort:
  - Stimulus: abort_i coincident with the 4th ack.
  - Response: no rnd_valid_o; edn_req_o=0 next cycle; rnd_data_o keeps its old value. A fresh request yields a full 8-word result.
- Reset mid-fill:
  - Stimulus: rst_i=1 at idx=6.
  - Response: all outputs return to reset values next cycle; no valid pulse; stray acks while IDLE are ignored.
- Counter (OTBN_RND_PACKER_CNT_EN):
  - Stimulus: 3 completed words then 1 aborted word.
  - Response: rnd_words_cnt_o=3. Without the macro it stays 0.

Source files
------------

// File: rtl/otbn_pkg.sv
// Shared OTBN constants and the RND packer state encoding.
package otbn_pkg;

  parameter int WLEN         = 256;
  parameter int EdnDataWidth = 32;

  typedef enum logic [1:0] {
    RndIdle,
    RndFill,
    RndValid
  } rnd_packer_state_e;

endpackage

// File: rtl/otbn_rnd_packer_if.sv
// Request/EDN/RND bus of the RND packer; master = packer, slave = environment.
interface otbn_rnd_packer_if #(
  parameter int Wlen         = otbn_pkg::WLEN,
  parameter int EdnDataWidth = otbn_pkg::EdnDataWidth
);
  logic                    rnd_req_i;
  logic                    abort_i;
  logic                    edn_req_o;
  logic                    edn_ack_i;
  logic [EdnDataWidth-1:0] edn_data_i;
  logic                    edn_fips_i;
  logic                    rnd_valid_o;
  logic [Wlen-1:0]         rnd_data_o;
  logic                    rnd_fips_o;
  logic                    busy_o;
  logic [31:0]             rnd_words_cnt_o;

  modport master (
    input  rnd_req_i, abort_i, edn_ack_i, edn_data_i, edn_fips_i,
    output edn_req_o, rnd_valid_o, rnd_data_o, rnd_fips_o, busy_o, rnd_words_cnt_o
  );

  modport slave (
    output rnd_req_i, abort_i, edn_ack_i, edn_data_i, edn_fips_i,
    input  edn_req_o, rnd_valid_o, rnd_data_o, rnd_fips_o, busy_o, rnd_words_cnt_o
  );
endinterface

// File: rtl/otbn_rnd_packer.sv
// Packs NumWords EDN words into one WLEN-bit RND word with a one-cycle valid pulse.
// Define OTBN_RND_PACKER_CNT_EN to build the saturating completed-word counter.
module otbn_rnd_packer #(
  parameter int Wlen         = otbn_pkg::WLEN,
  parameter int EdnDataWidth = otbn_pkg::EdnDataWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  otbn_rnd_packer_if.master  bus
);
  import otbn_pkg::*;

  localparam int NumWords = Wlen / EdnDataWidth;
  localparam int IdxW     = $clog2(NumWords);

  rnd_packer_state_e r_state, w_state_nxt;
  logic [IdxW-1:0]   r_idx;
  logic              r_pending;
  logic              r_fips_acc;
  logic [Wlen-1:0]   r_stage;
  logic [Wlen-1:0]   r_data;
  logic              r_fips;

  logic              w_ack;
  logic              w_last;
  logic [Wlen-1:0]   w_stage_nxt;
  logic              w_acc_nxt;

  assign w_ack     = bus.edn_ack_i && (r_state == RndFill);
  assign w_last    = (r_idx == IdxW'(NumWords - 1));
  assign w_acc_nxt = r_fips_acc & bus.edn_fips_i;

  // Staging with the incoming word merged, so the final word reaches rnd_data_o on the same edge.
  always_comb begin
    w_stage_nxt = r_stage;
    for (int w = 0; w < NumWords; w++) begin
      if (r_idx == IdxW'(w)) w_stage_nxt[w*EdnDataWidth +: EdnDataWidth] = bus.edn_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RndIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort_i) begin
      w_state_nxt = RndIdle;
    end else begin
      unique case (r_state)
        RndIdle:  if (bus.rnd_req_i) w_state_nxt = RndFill;
        RndFill:  if (w_ack && w_last) w_state_nxt = RndValid;
        RndValid: w_state_nxt = (r_pending || bus.rnd_req_i) ? RndFill : RndIdle;
        default:  w_state_nxt = RndIdle;
      endcase
    end
  end

  always_comb begin
    bus.edn_req_o   = (r_state == RndFill);
    bus.rnd_valid_o = (r_state == RndValid);
    bus.busy_o      = (r_state != RndIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_fips_acc <= 1'b0;
      r_stage    <= '0;
      r_data     <= '0;
      r_fips     <= 1'b0;
    end else if (bus.abort_i) begin
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_fips_acc <= 1'b0;
    end else begin
      unique case (r_state)
        RndIdle: begin
          if (bus.rnd_req_i) begin
            r_idx      <= '0;
            r_fips_acc <= 1'b1;
          end
        end
        RndFill: begin
          if (bus.rnd_req_i) r_pending <= 1'b1;
          if (w_ack) begin
            r_stage    <= w_stage_nxt;
            r_fips_acc <= w_acc_nxt;
            if (w_last) begin
              r_data <= w_stage_nxt;
              r_fips <= w_acc_nxt;
              r_idx  <= '0;
            end else begin
              r_idx <= r_idx + IdxW'(1);
            end
          end
        end
        RndValid: begin
          r_pending  <= 1'b0;
          r_idx      <= '0;
          r_fips_acc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rnd_data_o = r_data;
  assign bus.rnd_fips_o = r_fips;

`ifdef OTBN_RND_PACKER_CNT_EN
  logic [31:0] r_cnt;

  // Only reset clears the counter; abort leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                          r_cnt <= '0;
    else if (r_state == RndValid && r_cnt != '1)        r_cnt <= r_cnt + 32'd1;
  end

  assign bus.rnd_words_cnt_o = r_cnt;
`else
  assign bus.rnd_words_cnt_o = '0;
`endif

endmodule
